encrypt_top_level: RTL and testbench
====================================

// Module: encrypt_top_level
// PURPOSE
//  Self-contained message-encryption engine (Program #1). On start it reads a
//  raw message, preamble length, LFSR tap pattern and LFSR seed from its own
//  data memory. It writes a 64-byte space-padded, LFSR-XOR-encrypted copy back
//  to the same memory, then raises ack. It is the top of the design.
// PARAMETERS
//  DM_DEPTH   256  data-memory bytes (8-bit address)
//  MSG_BASE   0    first raw-message byte; chars are pre-biased (ASCII-0x20)
//  PRE_ADDR   61   preamble length (count of leading spaces)
//  TAP_ADDR   62   LFSR feedback tap pattern, bits[6:0]
//  SEED_ADDR  63   LFSR initial state, bits[6:0]
//  OUT_BASE   64   first encrypted output byte
//  NUM_BYTES  64   output length
// PORTS
//  clk   in  1  single clock; all state updates on the rising edge
//  init  in  1  reset: synchronous, active-high
//  req   in  1  start hold: engine stays idle while high; runs once low
//  ack   out 1  done flag: high after the last output byte is written
// BEHAVIOUR
//  Reset (init=1 at a clock edge): FSM goes to IDLE; ack=0, idx=0, lfsr=0, RF=0.
//   Data memory is NOT cleared. init mid-run aborts the run immediately.
//   Bytes already written remain in memory.
//  FSM states: IDLE -> LD_PRE -> LD_TAP -> LD_SEED -> RUN -> DONE.
//   IDLE: leave when init=0 and req=0.
//   LD_*: one cycle each; latch DM[61]/DM[62]/DM[63] into pre/tap/lfsr.
//   RUN:  one byte per cycle, idx 0..63; go to DONE after idx=63.
//   DONE: ack=1; held until init; req has no effect.
//  Per byte i in RUN:
//   - m = i-pre.
//   - p = (i>=pre && m<61) ? DM[MSG_BASE+m] : 8'h00. 0x00 is a biased space.
//   - DM[OUT_BASE+i] <= {PB, (p[6:0]^lfsr[6:0])}; write is synchronous.
//   - lfsr <= {1'b0, lfsr[5:0], ^(lfsr[6:0] & tap[6:0])}.
//  Key stream: byte 0 uses the seed itself. Seed bit7 and tap bit7 are ignored.
//   A zero seed is used unmodified (all-zero key).
//  No range check on pre; the m<61 guard makes any pre value safe.
//  Latency from the first edge with req=0 in IDLE: ack high 68 cycles later.
//  Data memory: combinational read, synchronous write, 1 write port.
//   Instance name DM, array core[0:DM_DEPTH-1] of 8 bits.
//  Register file: instance RF, array Registers[0:7] of 8 bits, updated in RUN.
//   R0 = current lfsr, R1 = idx, R2 = pre.
//   Others hold 0. Values after DONE: R0=lfsr after 64 steps, R1=63, R2=pre.
// CONFIGURATION
//  PARITY_EN defined:     PB = ^out[6:0] (even parity prepended in MSB).
//  PARITY_EN not defined: PB = 1'b0; bit7 of every output byte is zero.
// STRUCTURE
//  Package encrypt_pkg holds:
//   - state_t enum (IDLE, LD_PRE, LD_TAP, LD_SEED, RUN, DONE);
//   - address constants PRE_ADDR, TAP_ADDR, SEED_ADDR, MSG_BASE, OUT_BASE;
//   - NUM_BYTES and lfsr_next() function.
//  Sub-modules:
//   - data_mem (instance DM) is the natural sub-module.
//   - reg_file (instance RF) is a trivial register array.
//  Both instance names are fixed: benches preload and read DM.core and RF.Registers.
// TESTING
//  1 "Mr. Watson, come here. I want to see you.", pre=10, tap=0x60, seed=0x01:
//    release init then req; DM[64+i] must equal the model
//    ((pad[i]-0x20)^lfsr[i]) with MSB=0. DM[64]=0x01, DM[65]=0x02.
//  2 all-space message (DM[0..60]=0): output equals the pure key stream.
//    pre=26, tap=0x7B, seed=0x7F -> DM[64]=0x7F.
//  3 pre=10: DM[64..73] = key bytes 0..9.
//    DM[74] = DM[0]^key[10]; bytes past the message encrypt 0x00.
//  4 Hold req=1 for 100 cycles: ack stays 0, DM[64..127] untouched.
//    Then req=0 -> ack rises exactly 68 cycles later and stays high.
//  5 Assert init at idx=20: ack=0, FSM back in IDLE.
//    Rerun with req=0 gives the full correct result.
//  6 With PARITY_EN: bit7 of each DM[64+i] = XOR of its bits[6:0].

Source files
------------

// File: rtl/encrypt_pkg.sv
// Shared types, memory map constants and the LFSR step function for the
// message-encryption engine.
package encrypt_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_PRE  = 3'd1,
    LD_TAP  = 3'd2,
    LD_SEED = 3'd3,
    RUN     = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam int DM_DEPTH = 256;

  localparam logic [7:0] MSG_BASE  = 8'd0;
  localparam logic [7:0] PRE_ADDR  = 8'd61;
  localparam logic [7:0] TAP_ADDR  = 8'd62;
  localparam logic [7:0] SEED_ADDR = 8'd63;
  localparam logic [7:0] OUT_BASE  = 8'd64;
  localparam logic [7:0] NUM_BYTES = 8'd64;
  localparam logic [7:0] MSG_LEN   = 8'd61;
  localparam logic [7:0] LAST_IDX  = NUM_BYTES - 8'd1;

  // Seven-bit Fibonacci step; bit7 of both state and taps is never used.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s, input logic [7:0] t);
    return {1'b0, s[5:0], ^(s[6:0] & t[6:0])};
  endfunction

endpackage

// File: rtl/encrypt_top_level_data_mem.sv
// Byte-wide data memory: combinational read, single synchronous write port.
module data_mem #(
  parameter int DEPTH = 256
) (
  input  logic       clk,
  input  logic       wr_en,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] core [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (wr_en) core[wr_addr] <= wr_data;
  end

  assign rd_data = core[rd_addr];

endmodule

// File: rtl/encrypt_top_level_reg_file.sv
// Eight-entry status register file mirroring lfsr, idx and pre during RUN.
module reg_file (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [7:0] lfsr_val,
  input  logic [7:0] idx_val,
  input  logic [7:0] pre_val
);

  logic [7:0] Registers [0:7];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) Registers[i] <= 8'h00;
    end else if (we) begin
      Registers[0] <= lfsr_val;
      Registers[1] <= idx_val;
      Registers[2] <= pre_val;
    end
  end

endmodule

// File: rtl/encrypt_top_level.sv
// Message-encryption engine top: loads parameters from DM, writes 64 padded,
// LFSR-XORed bytes back. Define PARITY_EN to put even parity in bit7.
module encrypt_top_level
  import encrypt_pkg::*;
(
  input  logic clk,
  input  logic init,
  input  logic req,
  output logic ack
);

  state_t     state, state_nx;
  logic [7:0] idx, pre, tap, lfsr, lfsr_nx;
  logic [7:0] rd_addr, rd_data, wr_addr, wr_data;
  logic [7:0] m, p;
  logic [6:0] enc;
  logic       wr_en, in_msg, pb;

  data_mem #(.DEPTH(DM_DEPTH)) DM (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  reg_file RF (
    .clk      (clk),
    .rst      (init),
    .we       (wr_en),
    .lfsr_val (lfsr_nx),
    .idx_val  (idx),
    .pre_val  (pre)
  );

  always_ff @(posedge clk) begin
    if (init) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rd_addr  = MSG_BASE + m;
    case (state)
      IDLE:    if (!req) state_nx = LD_PRE;
      LD_PRE:  begin rd_addr = PRE_ADDR;  state_nx = LD_TAP;  end
      LD_TAP:  begin rd_addr = TAP_ADDR;  state_nx = LD_SEED; end
      LD_SEED: begin rd_addr = SEED_ADDR; state_nx = RUN;     end
      RUN:     if (idx == LAST_IDX) state_nx = DONE;
      DONE:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // Bytes before the preamble end or past the 61-char message encrypt a space.
  assign m       = idx - pre;
  assign in_msg  = (idx >= pre) && (m < MSG_LEN);
  assign p       = in_msg ? rd_data : 8'h00;
  assign enc     = p[6:0] ^ lfsr[6:0];
  assign lfsr_nx = lfsr_next(lfsr, tap);
`ifdef PARITY_EN
  assign pb      = ^enc;
`else
  assign pb      = 1'b0;
`endif
  assign wr_en   = (state == RUN) && !init;
  assign wr_addr = OUT_BASE + idx;
  assign wr_data = {pb, enc};

  always_ff @(posedge clk) begin
    if (init) begin
      ack  <= 1'b0;
      idx  <= 8'h00;
      lfsr <= 8'h00;
    end else begin
      case (state)
        LD_SEED: begin lfsr <= {1'b0, rd_data[6:0]}; idx <= 8'h00; end
        RUN:     begin lfsr <= lfsr_nx; idx <= idx + 8'd1; end
        DONE:    ack <= 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!init && state == LD_PRE) pre <= rd_data;
    if (!init && state == LD_TAP) tap <= rd_data;
  end

endmodule

// File: tb/tb_encrypt_top_level.sv
// Directed bench for encrypt_top_level with a scoreboard of expected output bytes.
module tb_encrypt_top_level;
  import encrypt_pkg::*;

  logic clk = 1'b0;
  logic init = 1'b1;
  logic req = 1'b1;
  logic ack;

  int checks = 0;
  int errors = 0;

  logic [7:0] msg [0:60];
  logic [7:0] key [0:63];
  logic [7:0] sb [$];
  logic [7:0] last_lfsr;
  int lat;

  encrypt_top_level dut (.clk(clk), .init(init), .req(req), .ack(ack));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_msg(input string s);
    for (int i = 0; i < 61; i++) msg[i] = 8'h00;
    for (int i = 0; i < s.len() && i < 61; i++) msg[i] = 8'(s[i]) - 8'h20;
  endtask

  task automatic load(input logic [7:0] pre, input logic [7:0] tap, input logic [7:0] seed);
    for (int i = 0; i < 61; i++) dut.DM.core[i] = msg[i];
    dut.DM.core[61] = pre;
    dut.DM.core[62] = tap;
    dut.DM.core[63] = seed;
    for (int i = 64; i < 128; i++) dut.DM.core[i] = 8'hAA;
  endtask

  task automatic push_model(input logic [7:0] pre, input logic [7:0] tap, input logic [7:0] seed);
    logic [7:0] k, p, e;
    int mm;
    k = {1'b0, seed[6:0]};
    for (int i = 0; i < 64; i++) begin
      mm = i - int'(pre);
      p = (i >= int'(pre) && mm < 61) ? msg[mm] : 8'h00;
      e = {1'b0, p[6:0] ^ k[6:0]};
`ifdef PARITY_EN
      e[7] = ^e[6:0];
`endif
      key[i] = k;
      sb.push_back(e);
      k = {1'b0, k[5:0], ^(k[6:0] & tap[6:0])};
    end
    last_lfsr = k;
  endtask

  task automatic go(output int l);
    @(negedge clk) req = 1'b0;
    l = -1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) begin l = c; break; end
    end
  endtask

  task automatic check_out(input string tag);
    logic [7:0] e, o;
    for (int i = 0; i < 64; i++) begin
      if (sb.size() == 0) begin
        chk({tag, "_sb_empty"}, 32'(i), 32'd64);
        break;
      end
      e = sb.pop_front();
      o = dut.DM.core[64+i];
      chk($sformatf("%s_byte%0d", tag, i), 32'(o), 32'(e));
`ifdef PARITY_EN
      chk($sformatf("%s_par%0d", tag, i), 32'(o[7]), 32'(^o[6:0]));
`else
      chk($sformatf("%s_msb%0d", tag, i), 32'(o[7]), 32'd0);
`endif
    end
  endtask

  task automatic do_reset();
    @(negedge clk) begin init = 1'b1; req = 1'b1; end
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ack", 32'(ack), 32'd0);
    chk("reset_state", 32'(dut.state), 32'(IDLE));
    @(negedge clk) init = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("init_ack", 32'(ack), 32'd0);
    chk("init_state", 32'(dut.state), 32'(IDLE));
    chk("init_idx", 32'(dut.idx), 32'd0);
    chk("init_lfsr", 32'(dut.lfsr), 32'd0);
    for (int r = 0; r < 8; r++) chk($sformatf("init_rf%0d", r), 32'(dut.RF.Registers[r]), 32'd0);

    // Hold req high with a loaded message: nothing may happen.
    set_msg("Mr. Watson, come here. I want to see you.");
    load(8'd10, 8'h60, 8'h01);
    @(negedge clk) init = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("hold_ack", 32'(ack), 32'd0);
    chk("hold_state", 32'(dut.state), 32'(IDLE));
    for (int i = 64; i < 128; i++) chk($sformatf("hold_dm%0d", i), 32'(dut.DM.core[i]), 32'hAA);

    // Watson message, pre=10.
    push_model(8'd10, 8'h60, 8'h01);
    go(lat);
    chk("watson_latency", 32'(lat), 32'd68);
    chk("watson_dm64", 32'(dut.DM.core[64][6:0]), 32'h01);
    chk("watson_dm65", 32'(dut.DM.core[65][6:0]), 32'h02);
    for (int i = 0; i < 10; i++) chk($sformatf("pre_key%0d", i), 32'(dut.DM.core[64+i][6:0]), 32'(key[i][6:0]));
    chk("pre_dm74", 32'(dut.DM.core[74][6:0]), 32'((msg[0] ^ key[10]) & 8'h7F));
    check_out("watson");
    chk("watson_rf0", 32'(dut.RF.Registers[0]), 32'(last_lfsr));
    chk("watson_rf1", 32'(dut.RF.Registers[1]), 32'd63);
    chk("watson_rf2", 32'(dut.RF.Registers[2]), 32'd10);
    chk("watson_rf3", 32'(dut.RF.Registers[3]), 32'd0);
    @(negedge clk) req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("done_ack_hold", 32'(ack), 32'd1);
    chk("done_state_hold", 32'(dut.state), 32'(DONE));

    // All-space message gives the raw key stream.
    do_reset();
    set_msg("");
    load(8'd26, 8'h7B, 8'h7F);
    push_model(8'd26, 8'h7B, 8'h7F);
    go(lat);
    chk("space_latency", 32'(lat), 32'd68);
    chk("space_dm64", 32'(dut.DM.core[64][6:0]), 32'h7F);
    check_out("space");

    // Seed/tap bit7 ignored, huge preamble, zero seed.
    do_reset();
    set_msg("HELLO");
    load(8'd200, 8'hE5, 8'h80);
    push_model(8'd200, 8'hE5, 8'h80);
    go(lat);
    chk("zseed_latency", 32'(lat), 32'd68);
    check_out("zseed");

    // pre=0 boundary: message starts at byte 0, bit7 of seed set.
    do_reset();
    set_msg("ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789abcdefghijklmnopqrstuvwxy");
    load(8'd0, 8'h41, 8'hD3);
    push_model(8'd0, 8'h41, 8'hD3);
    go(lat);
    chk("pre0_latency", 32'(lat), 32'd68);
    check_out("pre0");

    // Abort at idx=20, then a clean rerun.
    do_reset();
    set_msg("Mr. Watson, come here. I want to see you.");
    load(8'd10, 8'h60, 8'h01);
    push_model(8'd10, 8'h60, 8'h01);
    @(negedge clk) req = 1'b0;
    repeat (24) @(posedge clk);
    #1;
    chk("abort_idx_before", 32'(dut.idx), 32'd20);
    @(negedge clk) begin init = 1'b1; req = 1'b1; end
    @(posedge clk); #1;
    chk("abort_ack", 32'(ack), 32'd0);
    chk("abort_state", 32'(dut.state), 32'(IDLE));
    chk("abort_dm83", 32'(dut.DM.core[83]), 32'(sb[19]));
    chk("abort_dm84", 32'(dut.DM.core[84]), 32'hAA);
    sb.delete();
    @(negedge clk) init = 1'b0;
    load(8'd10, 8'h60, 8'h01);
    push_model(8'd10, 8'h60, 8'h01);
    go(lat);
    chk("rerun_latency", 32'(lat), 32'd68);
    check_out("rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
